// File: rtl/uc_mem_pkg.sv
// -----------------------------------------------------------------------------
// uc_mem_pkg
//   Shared constants for the uC data-memory responder and its timer.
//   Holds the timer register map, the register bit positions, the largest
//   allowed RAM size and a small address-window helper.
// -----------------------------------------------------------------------------
package uc_mem_pkg;

    // The data bus is fixed at 8 bits.
    localparam int DATA_W        = 8;

    // RAM occupies 0x00..RAM_DEPTH-1 and must stay below the timer window.
    localparam int MAX_RAM_DEPTH = 240;

    // Timer register map.
    localparam logic [7:0] TIMER_BASE  = 8'hF0;
    localparam logic [7:0] ADDR_TCTRL  = 8'hF0;
    localparam logic [7:0] ADDR_TPRESC = 8'hF1;
    localparam logic [7:0] ADDR_TCOUNT = 8'hF2;
    localparam logic [7:0] ADDR_TCMP   = 8'hF3;
    localparam logic [7:0] ADDR_TSTAT  = 8'hF4;

    // Bit positions inside TCTRL and TSTAT.
    localparam int TCTRL_EN      = 0;
    localparam int TCTRL_AUTOCLR = 1;
    localparam int TSTAT_MATCH   = 0;
    localparam int TSTAT_OVF     = 1;

    // Register index inside the timer window (address minus TIMER_BASE).
    typedef enum logic [2:0] {
        REG_TCTRL  = 3'd0,
        REG_TPRESC = 3'd1,
        REG_TCOUNT = 3'd2,
        REG_TCMP   = 3'd3,
        REG_TSTAT  = 3'd4
    } timer_reg_e;

    // True when the address hits one of the five implemented timer registers.
    function automatic logic is_timer_addr(input logic [7:0] a);
        return (a >= ADDR_TCTRL) && (a <= ADDR_TSTAT);
    endfunction

endpackage : uc_mem_pkg

// File: rtl/dmem_timer.sv
// -----------------------------------------------------------------------------
// dmem_timer
//   Memory-mapped 8-bit timer with a programmable prescaler, a compare register
//   and sticky MATCH / OVF flags.
//
//   Ports
//     clk      in   rising-edge clock
//     arst_n   in   asynchronous active-low reset, clears every register
//     sel      in   1 when the bus address lies inside the register window
//     wr_en    in   bus write strobe (only acts while sel=1)
//     reg_sel  in   register index inside the window (see timer_reg_e)
//     wr_data  in   bus write data
//     rd_data  out  register read data, 0 when sel=0
//     irq      out  MATCH | OVF
// -----------------------------------------------------------------------------
module dmem_timer
    import uc_mem_pkg::*;
(
    input  logic              clk,
    input  logic              arst_n,
    input  logic              sel,
    input  logic              wr_en,
    input  logic [2:0]        reg_sel,
    input  logic [DATA_W-1:0] wr_data,
    output logic [DATA_W-1:0] rd_data,
    output logic              irq
);

    timer_reg_e reg_e;

    logic [1:0]        tctrl_q,  tctrl_d;
    logic [DATA_W-1:0] tpresc_q, tpresc_d;
    logic [DATA_W-1:0] tcount_q, tcount_d;
    logic [DATA_W-1:0] tcmp_q,   tcmp_d;
    logic [1:0]        tstat_q,  tstat_d;
    logic [DATA_W-1:0] pcnt_q,   pcnt_d;

    logic wr_tctrl, wr_tpresc, wr_tcount, wr_tcmp, wr_tstat;
    logic en, autoclr;
    logic tick, match_hit, wrap_hit;

    assign reg_e     = timer_reg_e'(reg_sel);
    assign wr_tctrl  = sel && wr_en && (reg_e == REG_TCTRL);
    assign wr_tpresc = sel && wr_en && (reg_e == REG_TPRESC);
    assign wr_tcount = sel && wr_en && (reg_e == REG_TCOUNT);
    assign wr_tcmp   = sel && wr_en && (reg_e == REG_TCMP);
    assign wr_tstat  = sel && wr_en && (reg_e == REG_TSTAT);

    // Current-cycle control bits. A write clearing EN lands on the same edge
    // as any tick computed here, so that tick still completes.
    assign en      = tctrl_q[TCTRL_EN];
    assign autoclr = tctrl_q[TCTRL_AUTOCLR];

    assign tick      = en && (pcnt_q == tpresc_q);
    assign match_hit = tick && (tcount_q == tcmp_q);
    // Any incrementing step from 0xFF wraps; the AUTOCLR return to 0 is not a wrap.
    assign wrap_hit  = tick && !(match_hit && autoclr) && (tcount_q == 8'hFF);

    always_comb begin
        // NOTE: every signal gets a default before any branch so no latch is inferred.
        tctrl_d  = tctrl_q;
        tpresc_d = tpresc_q;
        tcount_d = tcount_q;
        tcmp_d   = tcmp_q;
        tstat_d  = tstat_q;
        pcnt_d   = pcnt_q + 8'd1;

        // Prescaler: idle at 0 while disabled, restart after each tick and
        // after any write that redefines the timebase or the count.
        if (!en || tick || wr_tpresc || wr_tcount) begin
            pcnt_d = '0;
        end

        if (tick) begin
            tcount_d = (match_hit && autoclr) ? '0 : tcount_q + 8'd1;
        end

        // A CPU load of TCOUNT overrides the tick increment.
        if (wr_tcount) tcount_d = wr_data;
        if (wr_tctrl)  tctrl_d  = wr_data[1:0];
        if (wr_tpresc) tpresc_d = wr_data;
        if (wr_tcmp)   tcmp_d   = wr_data;

        // W1C first, then hardware sets, so a set in the same cycle wins.
        if (wr_tstat) tstat_d = tstat_q & ~wr_data[1:0];
        if (match_hit) tstat_d[TSTAT_MATCH] = 1'b1;
        if (wrap_hit)  tstat_d[TSTAT_OVF]   = 1'b1;
    end

    always_ff @(posedge clk or negedge arst_n) begin
        if (!arst_n) begin
            tctrl_q  <= '0;
            tpresc_q <= '0;
            tcount_q <= '0;
            tcmp_q   <= '0;
            tstat_q  <= '0;
            pcnt_q   <= '0;
        end else begin
            // NOTE: non-blocking updates so every register samples pre-edge values.
            tctrl_q  <= tctrl_d;
            tpresc_q <= tpresc_d;
            tcount_q <= tcount_d;
            tcmp_q   <= tcmp_d;
            tstat_q  <= tstat_d;
            pcnt_q   <= pcnt_d;
        end
    end

    always_comb begin
        rd_data = '0;
        if (sel) begin
            case (reg_e)
                REG_TCTRL:  rd_data = {6'b0, tctrl_q};
                REG_TPRESC: rd_data = tpresc_q;
                REG_TCOUNT: rd_data = tcount_q;
                REG_TCMP:   rd_data = tcmp_q;
                REG_TSTAT:  rd_data = {6'b0, tstat_q};
                default:    rd_data = '0;
            endcase
        end
    end

    assign irq = tstat_q[TSTAT_MATCH] | tstat_q[TSTAT_OVF];

endmodule : dmem_timer

// File: rtl/data_mem_responder.sv
// -----------------------------------------------------------------------------
// data_mem_responder
//   Responder end of the uC data-memory bus. Maps the 8-bit address space onto
//   an internal RAM at 0x00..RAM_DEPTH-1 and, when built with DMEM_TIMER_EN,
//   an 8-bit timer at 0xF0..0xF4. All other addresses read 0 and ignore writes.
//   Reads are combinational (zero latency); writes commit on the rising edge.
//
//   Build option
//     DMEM_TIMER_EN  defined   : timer present, irq driven by its flags
//                    undefined : timer absent, 0xF0..0xFF unmapped, irq = 0
//
//   Parameters
//     RAM_DEPTH  number of RAM bytes, 1..240 (larger values are clamped to 240)
//
//   Ports
//     clk      in   rising-edge clock
//     arst_n   in   asynchronous active-low reset (timer registers only)
//     addr     in   byte address from the core
//     wr_en    in   write strobe
//     wr_data  in   write data
//     rd_data  out  read data for addr, combinational
//     irq      out  timer interrupt level
// -----------------------------------------------------------------------------
module data_mem_responder
    import uc_mem_pkg::*;
#(
    parameter int RAM_DEPTH = 240
)(
    input  logic              clk,
    input  logic              arst_n,
    input  logic [7:0]        addr,
    input  logic              wr_en,
    input  logic [DATA_W-1:0] wr_data,
    output logic [DATA_W-1:0] rd_data,
    output logic              irq
);

    // Keep the RAM clear of the timer window whatever the parameter says.
    localparam int DEPTH = (RAM_DEPTH > MAX_RAM_DEPTH) ? MAX_RAM_DEPTH :
                           (RAM_DEPTH < 1)             ? 1 : RAM_DEPTH;
    localparam int AW    = (DEPTH > 1) ? $clog2(DEPTH) : 1;

    logic [DATA_W-1:0] mem [DEPTH];
    logic              ram_hit;
    logic [AW-1:0]     ram_idx;

    assign ram_hit = (int'(addr) < DEPTH);
    assign ram_idx = addr[AW-1:0];

    // NOTE: the RAM array has no reset; its contents are undefined until written.
    always_ff @(posedge clk) begin
        if (wr_en && ram_hit) begin
            mem[ram_idx] <= wr_data;
        end
    end

`ifdef DMEM_TIMER_EN
    logic              timer_sel;
    logic [DATA_W-1:0] timer_rd;

    assign timer_sel = is_timer_addr(addr);

    dmem_timer u_timer (
        .clk     (clk),
        .arst_n  (arst_n),
        .sel     (timer_sel),
        .wr_en   (wr_en),
        .reg_sel (3'(addr - TIMER_BASE)),
        .wr_data (wr_data),
        .rd_data (timer_rd),
        .irq     (irq)
    );
`else
    // Without the timer the reset has nothing to clear.
    logic unused_arst_n;
    assign unused_arst_n = arst_n;
    assign irq           = 1'b0;
`endif

    always_comb begin
        rd_data = '0;
        if (ram_hit) begin
            rd_data = mem[ram_idx];
        end
`ifdef DMEM_TIMER_EN
        if (timer_sel) begin
            rd_data = timer_rd;
        end
`endif
    end

endmodule : data_mem_responder

// File: tb/tb_data_mem_responder.sv
// -----------------------------------------------------------------------------
// tb_data_mem_responder
//   Self-checking bench for data_mem_responder (RAM_DEPTH = 240). Works for
//   both builds: timer sequences are compiled only with DMEM_TIMER_EN.
// -----------------------------------------------------------------------------
module tb_data_mem_responder;

    localparam int RAM_DEPTH = 240;
    localparam int F0 = 8'hF0, F1 = 8'hF1, F2 = 8'hF2, F3 = 8'hF3, F4 = 8'hF4;

`ifdef DMEM_TIMER_EN
    localparam logic [7:0] EXP_F0 = 8'h03;
`else
    localparam logic [7:0] EXP_F0 = 8'h00;
`endif

    logic       clk = 1'b0;
    logic       arst_n;
    logic [7:0] addr;
    logic       wr_en;
    logic [7:0] wr_data;
    logic [7:0] rd_data;
    logic       irq;

    int checks   = 0;
    int failures = 0;

    data_mem_responder #(.RAM_DEPTH(RAM_DEPTH)) dut (
        .clk     (clk),
        .arst_n  (arst_n),
        .addr    (addr),
        .wr_en   (wr_en),
        .wr_data (wr_data),
        .rd_data (rd_data),
        .irq     (irq)
    );

    always #5 clk = ~clk;

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1);
    end

    // ---------------- reference model ----------------
    int m_ram [256];
    bit m_val [256];
    int m_ctrl, m_presc, m_count, m_cmp, m_stat, m_pcnt;

    function automatic void model_reset();
        m_ctrl = 0; m_presc = 0; m_count = 0; m_cmp = 0; m_stat = 0; m_pcnt = 0;
        for (int i = 0; i < 256; i++) m_val[i] = 1'b0;
    endfunction

    function automatic int model_read(int a);
        if (a < RAM_DEPTH) return m_ram[a];
`ifdef DMEM_TIMER_EN
        case (a)
            F0: return m_ctrl;
            F1: return m_presc;
            F2: return m_count;
            F3: return m_cmp;
            F4: return m_stat;
            default: ;
        endcase
`endif
        return 0;
    endfunction

    function automatic int model_irq();
`ifdef DMEM_TIMER_EN
        return (m_stat != 0) ? 1 : 0;
`else
        return 0;
`endif
    endfunction

    // Effect of one rising edge with the given bus inputs.
    function automatic void model_edge(int a, bit we, int d);
        bit en, ac, tick;
        int n_count, n_pcnt, n_stat, sets;
        if (we && a < RAM_DEPTH) begin
            m_ram[a] = d;
            m_val[a] = 1'b1;
        end
`ifdef DMEM_TIMER_EN
        en      = (m_ctrl & 1) != 0;
        ac      = (m_ctrl & 2) != 0;
        tick    = en && (m_pcnt == m_presc);
        n_count = m_count;
        n_stat  = m_stat;
        sets    = 0;
        if (tick) begin
            if (m_count == m_cmp) begin
                sets |= 1;
                if (ac) n_count = 0;
                else begin
                    n_count = (m_count + 1) % 256;
                    if (m_count == 255) sets |= 2;
                end
            end else begin
                n_count = (m_count + 1) % 256;
                if (m_count == 255) sets |= 2;
            end
        end
        n_pcnt = (en && !tick) ? m_pcnt + 1 : 0;
        if (we) begin
            case (a)
                F0: m_ctrl  = d & 3;
                F1: begin m_presc = d; n_pcnt = 0; end
                F2: begin n_count = d; n_pcnt = 0; end
                F3: m_cmp   = d;
                F4: n_stat  = m_stat & ~d & 3;
                default: ;
            endcase
        end
        m_stat  = n_stat | sets;
        m_count = n_count;
        m_pcnt  = n_pcnt;
`endif
    endfunction

    // ---------------- helpers ----------------
    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got 0x%0h expected 0x%0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    // One bus cycle: drive at the falling edge, sample before the rising edge.
    task automatic cyc(input int a, input bit we, input int d,
                       output logic [7:0] rd, output logic irq_s);
        @(negedge clk);
        addr    = a[7:0];
        wr_en   = we;
        wr_data = d[7:0];
        #1;
        rd    = rd_data;
        irq_s = irq;
        if (a >= RAM_DEPTH || m_val[a]) check($sformatf("rd@%02h", a), {24'b0, rd}, model_read(a));
        check("irq_model", {31'b0, irq_s}, model_irq());
        @(posedge clk);
        model_edge(a, we, d);
        #1;
        wr_en = 1'b0;
    endtask

    task automatic pulse_reset();
        @(negedge clk);
        wr_en = 1'b0;
        #2;
        arst_n = 1'b0;
        #1;
        check("rst_irq", {31'b0, irq}, 0);
        for (int a = F0; a <= F4; a++) begin
            addr = a[7:0];
            #1;
            check($sformatf("rst_reg@%02h", a), {24'b0, rd_data}, 0);
        end
        model_reset();
        @(negedge clk);
        arst_n = 1'b1;
    endtask

    typedef struct {
        logic [7:0] a;
        bit         we;
        logic [7:0] d;
        bit         chk;
        logic [7:0] exp;
    } vec_t;

    vec_t       vecs [12];
    logic [7:0] rd;
    logic       iq;

    initial begin
        vecs[0]  = '{8'h10, 1'b1, 8'h5A, 1'b0, 8'h00};
        vecs[1]  = '{8'h10, 1'b0, 8'h00, 1'b1, 8'h5A};
        vecs[2]  = '{8'hEF, 1'b0, 8'h00, 1'b1, 8'h8C};
        vecs[3]  = '{8'hF8, 1'b1, 8'h77, 1'b0, 8'h00};
        vecs[4]  = '{8'hF8, 1'b0, 8'h00, 1'b1, 8'h00};
        vecs[5]  = '{8'hF0, 1'b1, 8'h77, 1'b0, 8'h00};
        vecs[6]  = '{8'hF0, 1'b0, 8'h00, 1'b1, EXP_F0};
        vecs[7]  = '{8'hF0, 1'b1, 8'h00, 1'b0, 8'h00};
        vecs[8]  = '{8'h00, 1'b0, 8'h00, 1'b1, 8'h03};
        vecs[9]  = '{8'hF5, 1'b0, 8'h00, 1'b1, 8'h00};
        vecs[10] = '{8'hFF, 1'b1, 8'h12, 1'b0, 8'h00};
        vecs[11] = '{8'hFF, 1'b0, 8'h00, 1'b1, 8'h00};

        arst_n  = 1'b0;
        addr    = 8'h00;
        wr_en   = 1'b0;
        wr_data = 8'h00;
        model_reset();
        #1;
        check("reset_irq", {31'b0, irq}, 0);
        repeat (2) @(negedge clk);
        arst_n = 1'b1;

        // ---- RAM fill and table vectors ----
        for (int i = 0; i < RAM_DEPTH; i++) cyc(i, 1'b1, (i * 7 + 3) & 255, rd, iq);
        for (int i = 0; i < 12; i++) begin
            cyc(int'(vecs[i].a), vecs[i].we, int'(vecs[i].d), rd, iq);
            if (vecs[i].chk) check($sformatf("vec%0d", i), {24'b0, rd}, {24'b0, vecs[i].exp});
        end

`ifdef DMEM_TIMER_EN
        // ---- prescaled count up to a match, no AUTOCLR ----
        pulse_reset();
        cyc(F1, 1'b1, 3, rd, iq);
        cyc(F3, 1'b1, 2, rd, iq);
        cyc(F0, 1'b1, 1, rd, iq);
        for (int i = 0; i <= 13; i++) begin
            cyc((i == 13) ? F4 : F2, 1'b0, 0, rd, iq);
            if (i == 3)  check("presc_cnt3",  {24'b0, rd}, 0);
            if (i == 4)  check("presc_cnt4",  {24'b0, rd}, 1);
            if (i == 8)  check("presc_cnt8",  {24'b0, rd}, 2);
            if (i == 11) check("pre_match_irq", {31'b0, iq}, 0);
            if (i == 12) check("match_cnt",   {24'b0, rd}, 3);
            if (i == 12) check("match_irq",   {31'b0, iq}, 1);
            if (i == 13) check("match_stat",  {24'b0, rd}, 8'h01);
        end

        // ---- AUTOCLR: 0,1,2,0,1 ----
        pulse_reset();
        cyc(F1, 1'b1, 3, rd, iq);
        cyc(F3, 1'b1, 2, rd, iq);
        cyc(F0, 1'b1, 3, rd, iq);
        for (int i = 0; i <= 17; i++) begin
            cyc((i == 17) ? F4 : F2, 1'b0, 0, rd, iq);
            if (i == 8)  check("ac_cnt8",  {24'b0, rd}, 2);
            if (i == 12) check("ac_cnt12", {24'b0, rd}, 0);
            if (i == 16) check("ac_cnt16", {24'b0, rd}, 1);
            if (i == 17) check("ac_stat",  {24'b0, rd}, 8'h01);
        end

        // ---- overflow and W1C ----
        pulse_reset();
        cyc(F3, 1'b1, 8'h80, rd, iq);
        cyc(F2, 1'b1, 8'hFF, rd, iq);
        cyc(F1, 1'b1, 0, rd, iq);
        cyc(F0, 1'b1, 1, rd, iq);
        cyc(F2, 1'b0, 0, rd, iq);
        check("ovf_pre", {24'b0, rd}, 8'hFF);
        cyc(F2, 1'b0, 0, rd, iq);
        check("ovf_wrap", {24'b0, rd}, 8'h00);
        cyc(F4, 1'b0, 0, rd, iq);
        check("ovf_stat", {24'b0, rd}, 8'h02);
        check("ovf_irq", {31'b0, iq}, 1);
        cyc(F4, 1'b1, 8'h02, rd, iq);
        cyc(F4, 1'b0, 0, rd, iq);
        check("ovf_clr_stat", {24'b0, rd}, 8'h00);
        check("ovf_clr_irq", {31'b0, iq}, 0);

        // ---- same-cycle collisions ----
        pulse_reset();
        cyc(F1, 1'b1, 0, rd, iq);
        cyc(F3, 1'b1, 5, rd, iq);
        cyc(F2, 1'b1, 5, rd, iq);
        cyc(F0, 1'b1, 1, rd, iq);
        cyc(F4, 1'b1, 1, rd, iq);      // W1C of MATCH on the match tick
        cyc(F4, 1'b0, 0, rd, iq);
        check("w1c_vs_set", {24'b0, rd}, 8'h01);
        check("w1c_irq", {31'b0, iq}, 1);
        cyc(F2, 1'b1, 8'h40, rd, iq);  // load on a tick cycle
        cyc(F2, 1'b0, 0, rd, iq);
        check("load_vs_tick", {24'b0, rd}, 8'h40);
        cyc(F0, 1'b1, 0, rd, iq);      // disable on a tick cycle
        cyc(F2, 1'b0, 0, rd, iq);
        check("dis_tick_done", {24'b0, rd}, 8'h42);
        cyc(F2, 1'b0, 0, rd, iq);
        check("dis_halted", {24'b0, rd}, 8'h42);
        cyc(F0, 1'b1, 1, rd, iq);
`endif

        // ---- asynchronous reset while running ----
        pulse_reset();
        for (int a = F0; a <= F4; a++) begin
            cyc(a, 1'b0, 0, rd, iq);
            check($sformatf("post_rst@%02h", a), {24'b0, rd}, 0);
        end
        check("post_rst_irq", {31'b0, iq}, 0);

        // ---- randomized traffic against the model ----
        for (int n = 0; n < 3000; n++) begin
            int r, a, d;
            bit we;
            if (n == 1500) pulse_reset();
            r  = $urandom_range(0, 9);
            if (r < 4)      a = $urandom_range(0, RAM_DEPTH - 1);
            else if (r < 8) a = $urandom_range(F0, F4);
            else            a = $urandom_range(RAM_DEPTH, 255);
            we = 1'($urandom_range(0, 1));
            d  = $urandom_range(0, 255);
            if (a == F1) d = $urandom_range(0, 3);
            if (a == F3) d = $urandom_range(0, 15);
            if (a == F2 && $urandom_range(0, 1) == 1) d = 8'hFD;
            if (a == F0) d = ($urandom_range(0, 3) != 0) ? (d | 1) : d;
            cyc(a, we, d, rd, iq);
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule : tb_data_mem_responder
